// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the MM:SS stopwatch controller.
package stopwatch_pkg;
  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    S_PAUSE = 2'd0,
    S_RUN   = 2'd1,
    S_ADJ   = 2'd2
  } state_e;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t ONES_MAX     = 4'd9;

  typedef struct packed {
    bcd_t digit;
    logic carry;
  } bcd_inc_t;

  typedef struct packed {
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
  } mmss_t;

  // One BCD digit step: with carry-in, wrap at max and emit carry-out.
  function automatic bcd_inc_t bcd_inc(bcd_t d, bcd_t max, logic cin);
    bcd_inc_t r;
    r.digit = d;
    r.carry = 1'b0;
    if (cin) begin
      if (d == max) begin
        r.digit = '0;
        r.carry = 1'b1;
      end else begin
        r.digit = d + bcd_t'(1);
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/stopwatch_if.sv
// Stopwatch controller I/O bundle: tick strobes and user inputs in,
// BCD digits, blank masks and run status out.
interface stopwatch_if;
  import stopwatch_pkg::*;

  logic tick_1hz;
  logic tick_2hz;
  logic tick_4hz;
  logic btn_pause;
  logic btn_clr;
  logic sw_adj;
  logic sw_sel;
  bcd_t min_tens;
  bcd_t min_ones;
  bcd_t sec_tens;
  bcd_t sec_ones;
  logic blank_min;
  logic blank_sec;
  logic running;

  modport master (
    output tick_1hz, tick_2hz, tick_4hz, btn_pause, btn_clr, sw_adj, sw_sel,
    input  min_tens, min_ones, sec_tens, sec_ones, blank_min, blank_sec, running
  );

  modport slave (
    input  tick_1hz, tick_2hz, tick_4hz, btn_pause, btn_clr, sw_adj, sw_sel,
    output min_tens, min_ones, sec_tens, sec_ones, blank_min, blank_sec, running
  );
endinterface

// File: rtl/stopwatch_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stable-level counter, and a
// one-cycle pulse on each accepted rising edge.
module btn_debounce #(
  parameter int DB_CYCLES = 500000,
  parameter int DB_W      = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic press_o
);
  logic            s1_q, s2_q;
  logic            level_q;
  logic            press_q;
  logic [DB_W-1:0] cnt_q;

  // Bring the raw asynchronous level into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

  // Accept a new level only after DB_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (s2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
        cnt_q   <= '0;
        level_q <= s2_q;
        press_q <= s2_q;
      end else begin
        cnt_q <= cnt_q + DB_W'(1);
      end
    end
  end

  assign press_o = press_q;
endmodule

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch sequencing controller: run/pause/adjust FSM, BCD time
// registers, button debounce and display blank masks.
// Optional build macro STOPWATCH_BLINK_EN: blinks the selected field while
// adjusting; when undefined the blank outputs are tied low.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = 500000,
  parameter int DB_W      = 19
) (
  input  logic        clk,
  input  logic        rst,
  stopwatch_if.slave  sw
);
  logic     pause_press, clr_press;
  logic     adj_s1_q, adj_s2_q, sel_s1_q, sel_s2_q;
  state_e   state_q, state_d;
  logic     run_flag_q, run_flag_d;
  logic     running_q;
  mmss_t    time_q, time_d;
  bcd_inc_t inc;

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_pause (
    .clk(clk), .rst(rst), .raw_i(sw.btn_pause), .press_o(pause_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_clr (
    .clk(clk), .rst(rst), .raw_i(sw.btn_clr), .press_o(clr_press)
  );

  // Switches are level inputs: synchronize only, no debounce.
  always_ff @(posedge clk) begin
    if (rst) begin
      adj_s1_q <= 1'b0;
      adj_s2_q <= 1'b0;
      sel_s1_q <= 1'b0;
      sel_s2_q <= 1'b0;
    end else begin
      adj_s1_q <= sw.sw_adj;
      adj_s2_q <= adj_s1_q;
      sel_s1_q <= sw.sw_sel;
      sel_s2_q <= sel_s1_q;
    end
  end

  // Next state: outside adjust the state always mirrors run_flag, so leaving
  // adjust simply resumes whatever run_flag says.
  always_comb begin
    run_flag_d = run_flag_q ^ pause_press;
    if (adj_s2_q)        state_d = S_ADJ;
    else if (run_flag_d) state_d = S_RUN;
    else                 state_d = S_PAUSE;
  end

  // Time datapath: clear wins over any tick; adjust wraps a field with no carry out.
  always_comb begin
    time_d = time_q;
    inc    = '0;
    if (clr_press) begin
      time_d = '0;
    end else if (state_q == S_RUN && sw.tick_1hz) begin
      inc = bcd_inc(time_q.sec_ones, ONES_MAX, 1'b1);
      time_d.sec_ones = inc.digit;
      inc = bcd_inc(time_q.sec_tens, SEC_TENS_MAX, inc.carry);
      time_d.sec_tens = inc.digit;
      inc = bcd_inc(time_q.min_ones, ONES_MAX, inc.carry);
      time_d.min_ones = inc.digit;
      inc = bcd_inc(time_q.min_tens, SEC_TENS_MAX, inc.carry);
      time_d.min_tens = inc.digit;
    end else if (state_q == S_ADJ && sw.tick_2hz) begin
      if (sel_s2_q) begin
        inc = bcd_inc(time_q.sec_ones, ONES_MAX, 1'b1);
        time_d.sec_ones = inc.digit;
        inc = bcd_inc(time_q.sec_tens, SEC_TENS_MAX, inc.carry);
        time_d.sec_tens = inc.digit;
      end else begin
        inc = bcd_inc(time_q.min_ones, ONES_MAX, 1'b1);
        time_d.min_ones = inc.digit;
        inc = bcd_inc(time_q.min_tens, SEC_TENS_MAX, inc.carry);
        time_d.min_tens = inc.digit;
      end
    end
  end

  // FSM, run flag, time registers and registered running output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_PAUSE;
      run_flag_q <= 1'b0;
      running_q  <= 1'b0;
      time_q     <= '0;
    end else begin
      state_q    <= state_d;
      run_flag_q <= run_flag_d;
      running_q  <= (state_d == S_RUN);
      time_q     <= time_d;
    end
  end

  assign sw.min_tens = time_q.min_tens;
  assign sw.min_ones = time_q.min_ones;
  assign sw.sec_tens = time_q.sec_tens;
  assign sw.sec_ones = time_q.sec_ones;
  assign sw.running  = running_q;

`ifdef STOPWATCH_BLINK_EN
  logic blink_q, blink_d;
  logic blank_min_q, blank_sec_q;

  always_comb begin
    if (state_d != S_ADJ)                      blink_d = 1'b0;
    else if (state_q == S_ADJ && sw.tick_4hz)  blink_d = ~blink_q;
    else                                       blink_d = blink_q;
  end

  // Blink the selected field while adjusting; cleared on leaving adjust.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_q     <= 1'b0;
      blank_min_q <= 1'b0;
      blank_sec_q <= 1'b0;
    end else begin
      blink_q     <= blink_d;
      blank_min_q <= blink_d & ~sel_s2_q;
      blank_sec_q <= blink_d &  sel_s2_q;
    end
  end

  assign sw.blank_min = blank_min_q;
  assign sw.blank_sec = blank_sec_q;
`else
  logic unused_tick4;
  assign unused_tick4  = sw.tick_4hz;
  assign sw.blank_min  = 1'b0;
  assign sw.blank_sec  = 1'b0;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: seconds-based reference model checked every
// cycle, plus directed scenarios with literal expected times.
module tb_stopwatch_ctrl;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stopwatch_if sif ();

  stopwatch_ctrl #(.DB_CYCLES(DB), .DB_W(3)) dut (
    .clk(clk), .rst(rst), .sw(sif)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Reference model: time as integer minutes/seconds, mode as adjust/run flags.
  int       m_min = 0, m_sec = 0;
  bit       m_flag = 0, m_adjm = 0, m_run = 0, m_blink = 0, m_bmin = 0, m_bsec = 0;
  bit [7:0] hp = '0, hc = '0, ha = '0, hs = '0;  // raw samples, bit0 = newest
  bit       lv_p = 0, lv_c = 0, pend_p = 0, pend_c = 0;

  // The synced view lags raw by two samples; a level is accepted once the
  // last DB synced samples all hold it.
  function automatic bit held(input bit [7:0] h, input bit v);
    for (int k = 1; k <= DB; k++) if (h[k] != v) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin : model
    bit pp, cp, was_adj, was_run, sel;
    int tot;
    if (rst) begin
      m_min = 0; m_sec = 0; m_flag = 0; m_adjm = 0; m_run = 0;
      m_blink = 0; m_bmin = 0; m_bsec = 0;
      hp = '0; hc = '0; ha = '0; hs = '0;
      lv_p = 0; lv_c = 0; pend_p = 0; pend_c = 0;
    end else begin
      pp = pend_p; cp = pend_c; sel = hs[1]; was_adj = m_adjm; was_run = m_run;
      pend_p = 0;
      if (!lv_p && held(hp, 1'b1)) begin lv_p = 1; pend_p = 1; end
      else if (lv_p && held(hp, 1'b0)) lv_p = 0;
      pend_c = 0;
      if (!lv_c && held(hc, 1'b1)) begin lv_c = 1; pend_c = 1; end
      else if (lv_c && held(hc, 1'b0)) lv_c = 0;
      if (cp) begin
        m_min = 0; m_sec = 0;
      end else if (was_run && sif.tick_1hz) begin
        tot = (m_min * 60 + m_sec + 1) % 3600;
        m_min = tot / 60; m_sec = tot % 60;
      end else if (was_adj && sif.tick_2hz) begin
        if (sel) m_sec = (m_sec + 1) % 60;
        else     m_min = (m_min + 1) % 60;
      end
      m_flag = m_flag ^ pp;
      m_adjm = ha[1];
      m_run  = !m_adjm && m_flag;
`ifdef STOPWATCH_BLINK_EN
      if (!m_adjm) m_blink = 0;
      else if (was_adj && sif.tick_4hz) m_blink = !m_blink;
      m_bmin = m_blink && !sel;
      m_bsec = m_blink && sel;
`endif
      hp = {hp[6:0], sif.btn_pause};
      hc = {hc[6:0], sif.btn_clr};
      ha = {ha[6:0], sif.sw_adj};
      hs = {hs[6:0], sif.sw_sel};
    end
  end

  function automatic int dut_min();
    return int'(sif.min_tens) * 10 + int'(sif.min_ones);
  endfunction
  function automatic int dut_sec();
    return int'(sif.sec_tens) * 10 + int'(sif.sec_ones);
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({sif.min_tens, sif.min_ones, sif.sec_tens, sif.sec_ones} !==
          {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)} ||
          sif.running !== m_run || sif.blank_min !== m_bmin || sif.blank_sec !== m_bsec) begin
        failures++;
        $display("FAIL model_cmp t=%0t got %0h%0h:%0h%0h run=%b bl=%b%b want %02d:%02d run=%b bl=%b%b",
                 $time, sif.min_tens, sif.min_ones, sif.sec_tens, sif.sec_ones, sif.running,
                 sif.blank_min, sif.blank_sec, m_min, m_sec, m_run, m_bmin, m_bsec);
      end
    end
  end

  // Literal expectations pin both the DUT and the model.
  task automatic check_lit(input string nm, input int mm, input int ss, input bit run);
    @(negedge clk);
    checks++;
    if (dut_min() != mm || dut_sec() != ss || sif.running !== run ||
        sif.blank_min !== 1'b0 || sif.blank_sec !== 1'b0) begin
      failures++;
      $display("FAIL %s dut got %02d:%02d run=%b bl=%b%b want %02d:%02d run=%b bl=00",
               nm, dut_min(), dut_sec(), sif.running, sif.blank_min, sif.blank_sec, mm, ss, run);
    end
    checks++;
    if (m_min != mm || m_sec != ss || m_run != run) begin
      failures++;
      $display("FAIL %s model got %02d:%02d run=%b want %02d:%02d run=%b",
               nm, m_min, m_sec, m_run, mm, ss, run);
    end
  endtask

  task automatic check_blank(input string nm, input bit bmin, input bit bsec);
    @(negedge clk);
    checks++;
    if (sif.blank_min !== bmin || sif.blank_sec !== bsec) begin
      failures++;
      $display("FAIL %s got blank_min=%b blank_sec=%b want %b %b",
               nm, sif.blank_min, sif.blank_sec, bmin, bsec);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_tick(input int k, input bit v);
    case (k)
      1:       sif.tick_1hz = v;
      2:       sif.tick_2hz = v;
      default: sif.tick_4hz = v;
    endcase
  endtask

  task automatic tick(input int k, input int n);
    repeat (n) begin
      @(negedge clk); set_tick(k, 1'b1);
      @(negedge clk); set_tick(k, 1'b0);
    end
  endtask

  task automatic press(input bit p, input bit c, input int hold);
    @(negedge clk); sif.btn_pause = p; sif.btn_clr = c;
    cyc(hold);
    sif.btn_pause = 1'b0; sif.btn_clr = 1'b0;
    cyc(DB + 4);
  endtask

  task automatic set_sw(input bit adj, input bit sel);
    @(negedge clk); sif.sw_adj = adj; sif.sw_sel = sel;
    cyc(4);
  endtask

  // Raw clear rises ahead of edge a; its pulse acts on edge a+6, where the tick lands.
  task automatic clr_with_tick();
    @(negedge clk); sif.btn_clr = 1'b1;
    cyc(6);
    sif.btn_clr = 1'b0; sif.tick_1hz = 1'b1;
    @(negedge clk); sif.tick_1hz = 1'b0;
    cyc(DB + 4);
  endtask

  initial begin
    sif.tick_1hz = 0; sif.tick_2hz = 0; sif.tick_4hz = 0;
    sif.btn_pause = 0; sif.btn_clr = 0; sif.sw_adj = 0; sif.sw_sel = 0;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state, ticks ignored while paused
    check_lit("reset", 0, 0, 1'b0);
    tick(1, 3);
    check_lit("pause_ticks", 0, 0, 1'b0);

    // Start, count 61 s, short press filtered
    press(1'b1, 1'b0, 6);
    check_lit("start", 0, 0, 1'b1);
    tick(1, 61);
    check_lit("run61", 1, 1, 1'b1);
    press(1'b1, 1'b0, 2);
    check_lit("short_press", 1, 1, 1'b1);

    // Preload 59:58 via adjust, then full wrap
    set_sw(1'b1, 1'b0);
    press(1'b0, 1'b1, 6);
    check_lit("adj_clear", 0, 0, 1'b0);
    tick(2, 59);
    set_sw(1'b1, 1'b1);
    tick(2, 58);
    check_lit("preload", 59, 58, 1'b0);
    set_sw(1'b0, 1'b1);
    tick(1, 1);
    check_lit("t5959", 59, 59, 1'b1);
    tick(1, 1);
    check_lit("wrap", 0, 0, 1'b1);

    // Adjust minutes mod 60 with no carry; 1 Hz ignored in adjust
    tick(1, 10);
    check_lit("t0010", 0, 10, 1'b1);
    set_sw(1'b1, 1'b0);
    tick(2, 60);
    check_lit("adj_min60", 0, 10, 1'b0);
    set_sw(1'b1, 1'b1);
    tick(2, 1);
    check_lit("adj_sec", 0, 11, 1'b0);
    tick(1, 3);
    check_lit("adj_1hz_ign", 0, 11, 1'b0);

    // Clear beats a same-cycle tick; clear + pause together
    press(1'b0, 1'b1, 6);
    set_sw(1'b1, 1'b0);
    tick(2, 12);
    set_sw(1'b1, 1'b1);
    tick(2, 34);
    set_sw(1'b0, 1'b1);
    check_lit("t1234", 12, 34, 1'b1);
    clr_with_tick();
    check_lit("clr_tick", 0, 0, 1'b1);
    tick(1, 5);
    check_lit("t0005", 0, 5, 1'b1);
    press(1'b1, 1'b1, 6);
    check_lit("clr_pause", 0, 0, 1'b0);
    tick(1, 2);
    check_lit("paused_again", 0, 0, 1'b0);

    // Blink masks in adjust
    set_sw(1'b1, 1'b1);
    tick(4, 1);
`ifdef STOPWATCH_BLINK_EN
    check_blank("blink1", 1'b0, 1'b1);
`else
    check_blank("blink1", 1'b0, 1'b0);
`endif
    tick(4, 1);
    check_blank("blink2", 1'b0, 1'b0);
    tick(4, 1);
    set_sw(1'b0, 1'b1);
    check_blank("blink_exit", 1'b0, 1'b0);

    // Reset in the middle of adjusting
    press(1'b1, 1'b0, 6);
    tick(1, 3);
    check_lit("t0003", 0, 3, 1'b1);
    set_sw(1'b1, 1'b0);
    tick(2, 5);
    check_lit("t0503", 5, 3, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_lit("mid_reset", 0, 0, 1'b0);
    set_sw(1'b0, 1'b0);
    check_lit("post_reset", 0, 0, 1'b0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
